vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch (pixels).
REQ-003 Parameter H_SYNC, 96, horizontal sync width (pixels).
REQ-004 Parameter H_BP, 48, horizontal back porch (pixels).
REQ-005 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 Parameter V_FP, 10, vertical front porch (lines).
REQ-007 Parameter V_SYNC, 2, vertical sync width (lines).
REQ-008 Parameter V_BP, 33, vertical back porch (lines).
REQ-009 Parameter HS_POL, 0, asserted level of VGA_HSYNC.
REQ-010 Parameter VS_POL, 0, asserted level of VGA_VSYNC.
REQ-011 Parameter CE_DIV, 2, clk cycles per pixel (1..16).
REQ-012 Parameter HW, 10, width of HPIXEL; VW, 10, width of VPIXEL.
REQ-013 clk  input  1  system clock, all state on rising edge.
REQ-014 reset  input  1  asynchronous, active-low reset.
REQ-015 en  input  1  run enable; low freezes all state.
REQ-016 HPIXEL  output  HW  column of current pixel in active area, else 0.
REQ-017 VPIXEL  output  VW  row of current pixel in active area, else 0.
REQ-018 VGA_HSYNC  output  1  horizontal sync, level per HS_POL.
REQ-019 VGA_VSYNC  output  1  vertical sync, level per VS_POL.
REQ-020 DE  output  1  high while current pixel is in the active area.
REQ-021 LINE_START  output  1  one-clk pulse when hcnt becomes 0.
REQ-022 FRAME_START  output  1  one-clk pulse when (hcnt,vcnt) becomes (0,0).

Function
REQ-023 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL likewise; HW, VW >= clog2(H_TOTAL), clog2(V_TOTAL); elaboration fails otherwise.
REQ-024 Divider div counts 0..CE_DIV-1 while en=1; tick asserted in the cycle div==CE_DIV-1, div wraps to 0; CE_DIV=1 gives tick every enabled cycle.
REQ-025 On tick: hcnt increments; at H_TOTAL-1 it wraps to 0 and vcnt increments; vcnt at V_TOTAL-1 with hcnt wrap wraps to 0.
REQ-026 Line order: active [0,H_ACTIVE-1], front porch, sync, back porch; frame order identical in lines.
REQ-027 All outputs registered, updated on tick edges from post-increment counters, so outputs always decode current (hcnt,vcnt); zero extra latency.
REQ-028 DE = (hcnt<H_ACTIVE)&&(vcnt<V_ACTIVE); HPIXEL=hcnt, VPIXEL=vcnt when DE, else 0.
REQ-029 VGA_HSYNC=HS_POL when H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
REQ-030 VGA_VSYNC=VS_POL when V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL; edges coincide with hcnt=0.
REQ-031 LINE_START, FRAME_START high for exactly one clk (the tick edge update), low otherwise, regardless of CE_DIV.
REQ-032 en=0: div, counters and level outputs hold; pulse outputs forced 0; resume continues from held position with no skipped pixel.

Reset
REQ-033 reset low asynchronously sets div=0, hcnt=H_TOTAL-1, vcnt=V_TOTAL-1.
REQ-034 Reset outputs: HPIXEL=0, VPIXEL=0, DE=0, VGA_HSYNC=~HS_POL, VGA_VSYNC=~VS_POL, LINE_START=0, FRAME_START=0.
REQ-035 First tick after release moves to (0,0): FRAME_START=1, LINE_START=1, DE=1 for that clk; reset mid-frame restarts identically.

Verification
REQ-036 Default params, hold reset low 5 clk -> REQ-034 values; release, en=1 -> FRAME_START pulse on clk 2, DE=1, HPIXEL=0, VPIXEL=0.
REQ-037 Default params -> VGA_HSYNC low for 192 clk starting at hcnt=656; LINE_START period 1600 clk; DE high 1280 clk per active line.
REQ-038 Default params -> VGA_VSYNC low during lines 490-491 (1 line = 1600 clk); FRAME_START period 840000 clk; DE never high for vcnt>=480.
REQ-039 en low 37 clk at hcnt=100 mid-line -> all outputs frozen, no pulses; after en high HPIXEL resumes 101 on next tick.
REQ-040 H_ACTIVE=4,H_FP=1,H_SYNC=2,H_BP=1,V_ACTIVE=3,V_FP=1,V_SYNC=1,V_BP=1,CE_DIV=1,HS_POL=VS_POL=1 -> HSYNC high hcnt 5-6, VSYNC high vcnt 4, frame = 48 clk, wrap to (0,0) with FRAME_START.
REQ-041 Assert reset at hcnt=300,vcnt=200 -> outputs return to REQ-034 values asynchronously; restart per REQ-035.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: run enable toward the generator, pixel position, syncs and pulses back out.
interface vga_timing_gen_if #(
  parameter int unsigned HW = 10,
  parameter int unsigned VW = 10
) ();
  logic          en;
  logic [HW-1:0] HPIXEL;
  logic [VW-1:0] VPIXEL;
  logic          VGA_HSYNC;
  logic          VGA_VSYNC;
  logic          DE;
  logic          LINE_START;
  logic          FRAME_START;

  modport master (
    input  en,
    output HPIXEL, VPIXEL, VGA_HSYNC, VGA_VSYNC, DE, LINE_START, FRAME_START
  );

  modport slave (
    output en,
    input  HPIXEL, VPIXEL, VGA_HSYNC, VGA_VSYNC, DE, LINE_START, FRAME_START
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters and registered sync/DE decode.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CE_DIV   = 2,
  parameter int unsigned HW       = 10,
  parameter int unsigned VW       = 10
) (
  input  logic clk,
  input  logic reset,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned DW       = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

  // Reject parameter sets the counters cannot represent.
  if (HW < $clog2(H_TOTAL)) begin : g_hw_chk
    $error("vga_timing_gen: HW too small for H_TOTAL");
  end
  if (VW < $clog2(V_TOTAL)) begin : g_vw_chk
    $error("vga_timing_gen: VW too small for V_TOTAL");
  end
  if (CE_DIV < 1 || CE_DIV > 16) begin : g_div_chk
    $error("vga_timing_gen: CE_DIV out of range 1..16");
  end

  logic [DW-1:0] div, div_nxt;
  logic [HW-1:0] hcnt, h_nxt;
  logic [VW-1:0] vcnt, v_nxt;
  logic          tick;
  logic          de_n, hs_n, vs_n;
  int unsigned   hn, vn;

  // Next position and its decode; outputs register these so they always match the counters.
  always_comb begin
    tick    = vga.en && (div == DW'(CE_DIV - 1));
    div_nxt = div;
    h_nxt   = hcnt;
    v_nxt   = vcnt;
    if (vga.en) div_nxt = tick ? '0 : div + DW'(1);
    if (tick) begin
      if (hcnt == HW'(H_TOTAL - 1)) begin
        h_nxt = '0;
        v_nxt = (vcnt == VW'(V_TOTAL - 1)) ? '0 : vcnt + VW'(1);
      end else begin
        h_nxt = hcnt + HW'(1);
      end
    end
    hn   = 32'(h_nxt);
    vn   = 32'(v_nxt);
    de_n = (hn < H_ACTIVE) && (vn < V_ACTIVE);
    hs_n = (hn >= HS_START) && (hn < HS_END);
    vs_n = (vn >= VS_START) && (vn < VS_END);
  end

  // Reset parks the counters on the last pixel so the first tick lands on (0,0).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div             <= '0;
      hcnt            <= HW'(H_TOTAL - 1);
      vcnt            <= VW'(V_TOTAL - 1);
      vga.HPIXEL      <= '0;
      vga.VPIXEL      <= '0;
      vga.DE          <= 1'b0;
      vga.VGA_HSYNC   <= ~HS_POL;
      vga.VGA_VSYNC   <= ~VS_POL;
      vga.LINE_START  <= 1'b0;
      vga.FRAME_START <= 1'b0;
    end else begin
      div             <= div_nxt;
      hcnt            <= h_nxt;
      vcnt            <= v_nxt;
      vga.LINE_START  <= tick && (h_nxt == '0);
      vga.FRAME_START <= tick && (h_nxt == '0) && (v_nxt == '0);
      if (tick) begin
        vga.HPIXEL    <= de_n ? h_nxt : '0;
        vga.VPIXEL    <= de_n ? v_nxt : '0;
        vga.DE        <= de_n;
        vga.VGA_HSYNC <= hs_n ? HS_POL : ~HS_POL;
        vga.VGA_VSYNC <= vs_n ? VS_POL : ~VS_POL;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing on one instance, a tiny 8x6 raster on a second.
module tb_vga_timing_gen;

  logic clk;
  logic rst0, rst1;
  int   n_chk, n_pass;

  vga_timing_gen_if #(.HW(10), .VW(10)) if0 ();
  vga_timing_gen_if #(.HW(4),  .VW(4))  if1 ();

  vga_timing_gen u_dut0 (
    .clk   (clk),
    .reset (rst0),
    .vga   (if0.master)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CE_DIV(1), .HW(4), .VW(4)
  ) u_dut1 (
    .clk   (clk),
    .reset (rst1),
    .vga   (if1.master)
  );

  logic [24:0] obs0;
  logic [12:0] obs1;
  assign obs0 = {if0.HPIXEL, if0.VPIXEL, if0.DE, if0.VGA_HSYNC, if0.VGA_VSYNC,
                 if0.LINE_START, if0.FRAME_START};
  assign obs1 = {if1.HPIXEL, if1.VPIXEL, if1.DE, if1.VGA_HSYNC, if1.VGA_VSYNC,
                 if1.LINE_START, if1.FRAME_START};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  initial begin
    int de_cnt, hs_cnt, hs_first, ls_cnt, ls_first, vs_low, fs_cnt;
    logic [12:0] exp1;
    n_chk = 0; n_pass = 0;
    rst0 = 1'b0; rst1 = 1'b0;
    if0.en = 1'b0; if1.en = 1'b0;

    // Reset values on both instances.
    repeat (5) @(negedge clk);
    chk("rst0_vec", 32'(obs0), 32'({10'd0, 10'd0, 5'b01100}));
    chk("rst1_vec", 32'(obs1), 32'({4'd0, 4'd0, 5'b00000}));

    // Release, first tick on clk 2 lands on (0,0).
    rst0 = 1'b1; if0.en = 1'b1;
    @(negedge clk);
    chk("fs_clk1", 32'(if0.FRAME_START), 32'd0);
    @(negedge clk);
    chk("fs_clk2", 32'(if0.FRAME_START), 32'd1);
    chk("ls_clk2", 32'(if0.LINE_START), 32'd1);
    chk("de_clk2", 32'(if0.DE), 32'd1);
    chk("hpix_clk2", 32'(if0.HPIXEL), 32'd0);
    chk("vpix_clk2", 32'(if0.VPIXEL), 32'd0);

    // One full line at CE_DIV=2.
    de_cnt = 0; hs_cnt = 0; hs_first = -1; ls_cnt = 0; ls_first = -1; vs_low = 0; fs_cnt = 0;
    for (int k = 1; k <= 1600; k++) begin
      @(negedge clk);
      if (if0.DE) de_cnt++;
      if (!if0.VGA_HSYNC) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = k;
      end
      if (if0.LINE_START) begin
        ls_cnt++;
        if (ls_first < 0) ls_first = k;
      end
      if (!if0.VGA_VSYNC) vs_low++;
      if (if0.FRAME_START) fs_cnt++;
    end
    chk("de_per_line", 32'(de_cnt), 32'd1280);
    chk("hs_low_len", 32'(hs_cnt), 32'd192);
    chk("hs_low_start", 32'(hs_first), 32'd1312);
    chk("ls_period", 32'(ls_first), 32'd1600);
    chk("ls_count", 32'(ls_cnt), 32'd1);
    chk("vs_low_line0", 32'(vs_low), 32'd0);
    chk("fs_in_line", 32'(fs_cnt), 32'd0);
    chk("line1_start", 32'(obs0), 32'({10'd0, 10'd1, 5'b11110}));

    // Freeze at hcnt=100 on line 1.
    repeat (200) @(negedge clk);
    chk("hpix_100", 32'(if0.HPIXEL), 32'd100);
    chk("vpix_1", 32'(if0.VPIXEL), 32'd1);
    if0.en = 1'b0;
    for (int k = 0; k < 37; k++) begin
      @(negedge clk);
      chk("freeze", 32'(obs0), 32'({10'd100, 10'd1, 5'b11100}));
    end
    if0.en = 1'b1;
    @(negedge clk);
    chk("resume_hold", 32'(if0.HPIXEL), 32'd100);
    @(negedge clk);
    chk("resume_101", 32'(if0.HPIXEL), 32'd101);

    // Asynchronous reset mid-line, then restart.
    #2 rst0 = 1'b0;
    #1 chk("async_rst0", 32'(obs0), 32'({10'd0, 10'd0, 5'b01100}));
    repeat (3) @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    chk("restart_fs_clk1", 32'(if0.FRAME_START), 32'd0);
    @(negedge clk);
    chk("restart_clk2", 32'(obs0), 32'({10'd0, 10'd0, 5'b11111}));

    // Tiny raster: 8 pixels x 6 lines, CE_DIV=1, positive syncs, two frames.
    rst1 = 1'b1; if1.en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 96; k++) begin
      int h, v;
      logic de;
      h  = k % 8;
      v  = (k / 8) % 6;
      de = (h < 4) && (v < 3);
      exp1 = {de ? 4'(h) : 4'd0, de ? 4'(v) : 4'd0, de,
              1'((h >= 5) && (h < 7)), 1'(v == 4), 1'(h == 0), 1'((k % 48) == 0)};
      chk("small_raster", 32'(obs1), 32'(exp1));
      @(negedge clk);
    end
    chk("small_wrap_fs", 32'(if1.FRAME_START), 32'd1);

    // Mid-frame asynchronous reset on the tiny raster.
    repeat (21) @(negedge clk);
    chk("small_mid", 32'(obs1), 32'({4'd0, 4'd0, 5'b01000}));
    #2 rst1 = 1'b0;
    #1 chk("async_rst1", 32'(obs1), 32'({4'd0, 4'd0, 5'b00000}));
    repeat (2) @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    chk("small_restart", 32'(obs1), 32'({4'd0, 4'd0, 5'b10011}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
